// File: rtl/noc_demux_four.sv
// 1-to-4 flit splitter: a single hold register feeds four per-destination FIFOs,
// each with its own valid/ready output. Order is preserved per destination.
module noc_demux_four #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 2,
    parameter int DEST_LSB = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic               busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             holdValid;
    logic [WIDTH-1:0] holdData;
    logic [1:0]       holdDest;
    logic [3:0]       fifoFull;
    logic             dispatch;
    logic             accept;

    // A full target stalls the hold register even if that FIFO pops this cycle.
    assign dispatch = holdValid && !fifoFull[holdDest];
    assign in_ready = !holdValid || dispatch;
    assign accept   = in_valid && in_ready;
    assign busy     = holdValid || (|out_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            holdValid <= 1'b0;
            holdData  <= '0;
            holdDest  <= '0;
        end else if (accept) begin
            holdValid <= 1'b1;
            holdData  <= in_data;
            holdDest  <= in_data[DEST_LSB +: 2];
        end else if (dispatch) begin
            holdValid <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gFifo
            logic [WIDTH-1:0] mem [DEPTH];
            logic [PTR_W-1:0] wrPtr;
            logic [PTR_W-1:0] rdPtr;
            logic [CNT_W-1:0] cnt;
            logic             push;
            logic             pop;

            assign push          = dispatch && (holdDest == 2'(gi));
            assign pop           = out_valid[gi] && out_ready[gi];
            assign fifoFull[gi]  = (cnt == CNT_W'(DEPTH));
            assign out_valid[gi] = (cnt != '0);
            assign out_data[gi*WIDTH +: WIDTH] = out_valid[gi] ? mem[rdPtr] : '0;

            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wrPtr] <= holdData;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wrPtr <= '0;
                    rdPtr <= '0;
                    cnt   <= '0;
                end else begin
                    if (push) begin
                        wrPtr <= wrPtr + 1'b1;
                    end
                    if (pop) begin
                        rdPtr <= rdPtr + 1'b1;
                    end
                    case ({push, pop})
                        2'b10:   cnt <= cnt + 1'b1;
                        2'b01:   cnt <= cnt - 1'b1;
                        default: cnt <= cnt;
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_noc_demux_four.sv
// Directed and random checks of noc_demux_four against a per-destination scoreboard.
module tb_noc_demux_four;

    logic         clk;
    logic         reset;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic         busy;

    int errCount   = 0;
    int checkCount = 0;
    int cyc        = 0;
    int xfers      = 0;
    int accCount   = 0;
    bit latChk     = 0;
    bit accepted   = 0;

    logic [31:0] expData [4][$];
    int          expCyc  [4][$];

    noc_demux_four #(.WIDTH(32), .DEPTH(2), .DEST_LSB(30)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checkCount++;
        assert (obs === expv) else begin
            errCount++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int outstanding();
        int n = 0;
        for (int i = 0; i < 4; i++) n += expData[i].size();
        return n;
    endfunction

    // Sample just after the inputs settle, score the transfers of the coming edge, then clock.
    task automatic step();
        #1;
        chk("busy", busy, outstanding() != 0);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] slice;
            slice = out_data[i*32 +: 32];
            if (!out_valid[i]) begin
                chk("idle_zero", slice, 0);
            end else if (out_ready[i]) begin
                chk("spurious_out", expData[i].size() == 0, 0);
                if (expData[i].size() != 0) begin
                    chk("out_data", slice, expData[i][0]);
                    if (latChk) chk("latency", cyc - expCyc[i][0], 2);
                    void'(expData[i].pop_front());
                    void'(expCyc[i].pop_front());
                    xfers++;
                end
            end
        end
        accepted = in_valid && in_ready;
        if (accepted) begin
            expData[in_data[31:30]].push_back(in_data);
            expCyc[in_data[31:30]].push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            step();
            n++;
        end while (!accepted && n < 200);
        chk("send_accept", accepted, 1);
        $display("send data=%08h dest=%0d cycle=%0d", d, d[31:30], cyc);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 4'hF;
        while ((outstanding() != 0 || busy) && n < 50) begin
            step();
            n++;
        end
        chk("drain_empty", outstanding(), 0);
        chk("drain_busy", busy, 0);
    endtask

    initial begin
        logic [1:0] dv;
        int n;
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 4'h0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-stream with three flits buffered
        send(32'h0000_0011);
        send(32'h4000_0022);
        send(32'h8000_0033);
        step();
        step();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_valid", out_valid, 4'b0111);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_data", out_data, 0);
        for (int i = 0; i < 4; i++) begin
            expData[i].delete();
            expCyc[i].delete();
        end
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_rst_valid", out_valid, 0);
        end
        $display("reset test done cycle=%0d", cyc);

        // Routing with latency check
        latChk = 1;
        send(32'h1234_4566);
        send(32'h5234_4567);
        send(32'h9234_4568);
        send(32'hD234_4569);
        drain();
        latChk = 0;

        // Back-pressure on output 2
        out_ready = 4'b1011;
        send(32'h8000_0001);
        send(32'h8000_0002);
        send(32'h8000_0003);
        in_valid = 1'b1;
        in_data  = 32'h8000_0004;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_not_accepted", accepted, 0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid2", out_valid[2], 1);
            chk("bp_head", out_data[95:64], 32'h8000_0001);
        end
        out_ready = 4'hF;
        n = 0;
        do begin
            step();
            n++;
        end while (!accepted && n < 20);
        chk("bp_fourth_accept", accepted, 1);
        in_valid = 1'b0;
        drain();

        // Head-of-line blocking behind a full output 1
        out_ready = 4'b1100;
        send(32'h0000_00A0);
        send(32'h4000_00B1);
        send(32'h4000_00C1);
        send(32'h4000_00D1);
        in_valid = 1'b1;
        in_data  = 32'hC000_00E3;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hol_blocked", accepted, 0);
            chk("hol_out3_idle", out_valid[3], 0);
            chk("hol_out0_valid", out_valid[0], 1);
            chk("hol_out0_stable", out_data[31:0], 32'h0000_00A0);
        end
        out_ready = 4'b1101;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("hol_still_blocked", accepted, 0);
            chk("hol_out3_idle2", out_valid[3], 0);
        end
        chk("hol_out0_drained", out_valid[0], 0);
        out_ready = 4'hF;
        n = 0;
        do begin
            step();
            n++;
        end while (!accepted && n < 20);
        chk("hol_e_accept", accepted, 1);
        in_valid = 1'b0;
        drain();

        // Throughput: 64 flits in 66 cycles
        out_ready = 4'hF;
        xfers     = 0;
        accCount  = 0;
        for (int k = 0; k < 66; k++) begin
            if (k < 64) begin
                dv       = 2'($urandom_range(3, 0));
                in_valid = 1'b1;
                in_data  = {dv, 30'(k)};
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (accepted) accCount++;
        end
        chk("tput_accepts", accCount, 64);
        chk("tput_xfers", xfers, 64);
        chk("tput_busy", busy, 0);
        $display("throughput accepts=%0d transfers=%0d in 66 cycles", accCount, xfers);

        // Random stress
        accCount = 0;
        n = 0;
        while (accCount < 1000 && n < 20000) begin
            dv        = 2'($urandom_range(3, 0));
            in_valid  = ($urandom_range(9, 0) < 7);
            in_data   = {dv, 30'($urandom)};
            out_ready = 4'($urandom);
            step();
            if (accepted) accCount++;
            n++;
        end
        chk("stress_accepts", accCount, 1000);
        drain();
        $display("stress accepted=%0d cycles=%0d", accCount, n);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
